// File: rtl/pipelined_ripple_adder_pkg.sv
// Shared definitions for the pipelined ripple adder: operation encoding and
// pipeline geometry helpers used at elaboration time.
package pipelined_ripple_adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int unsigned slice_width(input int unsigned width,
                                              input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  function automatic bit geometry_ok(input int unsigned width,
                                     input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit ripple-carry slice built from a chain of full adders;
// also exposes the carry into its MSB for signed-overflow detection.
module adder_slice
  import pipelined_ripple_adder_pkg::*;
#(
  parameter int unsigned SW = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co,
  output logic          c_msb_in
);

  logic [SW:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < SW; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co       = c[SW];
  assign c_msb_in = c[SW-1];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// WIDTH-bit add/subtract split into STAGES registered ripple slices with a
// valid/ready handshake; one op per cycle, latency STAGES, global stall.
module pipelined_ripple_adder
  import pipelined_ripple_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SW = slice_width(WIDTH, STAGES);

  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $fatal(1, "pipelined_ripple_adder: WIDTH must be a multiple of STAGES (1..WIDTH)");
  end

  // Each stage carries the full operands forward; only bits at or above its
  // own slice are still consumed downstream.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;
  } stage_t;

  stage_t        stage_in [STAGES];
  stage_t        stage_d  [STAGES];
  stage_t        stage_q  [STAGES];
  logic [SW-1:0] sl_s     [STAGES];
  logic          sl_co    [STAGES];
  logic          sl_cmsb  [STAGES];
  logic          adv;
  op_e           op;

  always_comb begin
    op          = op_e'(sub);
    stage_in[0] = '{valid: in_valid,
                    a:     a,
                    b:     (op == OP_SUB) ? ~b : b,
                    s:     '0,
                    c:     (op == OP_SUB) ? ~cin : cin,
                    ovf:   1'b0};
    for (int unsigned k = 1; k < STAGES; k++) begin
      stage_in[k] = stage_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    adder_slice #(.SW(SW)) u_slice (
      .a        (stage_in[k].a[k*SW +: SW]),
      .b        (stage_in[k].b[k*SW +: SW]),
      .ci       (stage_in[k].c),
      .s        (sl_s[k]),
      .co       (sl_co[k]),
      .c_msb_in (sl_cmsb[k])
    );
  end

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      stage_d[k]                  = stage_in[k];
      stage_d[k].s[k*SW +: SW]    = sl_s[k];
      stage_d[k].c                = sl_co[k];
      stage_d[k].ovf              = sl_co[k] ^ sl_cmsb[k];
    end
  end

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign out_valid = stage_q[STAGES-1].valid;
  assign sum       = stage_q[STAGES-1].s;
  assign cout      = stage_q[STAGES-1].c;
  assign ovf       = stage_q[STAGES-1].ovf;

endmodule
